leaf_port_buffer: RTL and testbench

- Parametrised per-port elastic buffer between leaf_interface and the user kernel inside a leaf shell; generalises fixed iNoM leaf shells to any input/output port count and payload width.
- One FIFO per input channel (interface->user) and per output channel (user->interface); all use vld/ack handshakes.
- Adds three things fixed shells lack: a DFX decouple gate on the user side, a synchronous flush, and a leaf idle indication for safe partial reconfiguration.

---
 rtl/leaf_port_buffer.sv | 162 ++++++++++++++++
 tb/tb_leaf_port_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_port_buffer.sv
// Per-port elastic buffering between leaf_interface and the user kernel.
// The user side can be decoupled for DFX, all FIFOs can be flushed, and idle reports when everything is drained.
module leaf_port_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_vld,
  output logic              wr_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  input  logic              rd_ack,
  output logic              empty,
  output logic              stall_trip
);
  localparam int DEPTH    = 2 ** DEPTH_BITS;
  localparam int WD_LIMIT = DEPTH + 64;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;
  logic [WD_W-1:0]     stall_cnt;
  logic                full;
  logic                hold;
  logic                do_wr;
  logic                do_rd;
  logic                stalled;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                   (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
  assign hold    = rst | flush;
  assign wr_ack  = wr_en & ~full & ~hold;
  assign rd_vld  = rd_en & ~empty & ~hold;
  // Head word is masked whenever it is not offered, so the output never carries unwritten memory.
  assign rd_data = rd_vld ? mem[rd_ptr[DEPTH_BITS-1:0]] : '0;
  assign do_wr   = wr_vld & wr_ack;
  assign do_rd   = rd_vld & rd_ack;
  assign stalled = wr_en & wr_vld & full & ~hold;
  assign stall_trip = stalled && (stall_cnt == WD_MAX);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (hold) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Counts consecutive cycles a producer is held off by a full FIFO; saturates at the trip point.
  always_ff @(posedge clk) begin
    if (rst || !stalled) begin
      stall_cnt <= '0;
    end else if (stall_cnt != WD_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

module leaf_port_buffer #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 6,
  parameter int NUM_OUT_PORTS = 5,
  parameter int DEPTH_BITS    = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 decouple,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_interface2buf,
  input  logic [NUM_IN_PORTS-1:0]               vld_interface2buf,
  output logic [NUM_IN_PORTS-1:0]               ack_buf2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_buf2user,
  output logic [NUM_IN_PORTS-1:0]               vld_buf2user,
  input  logic [NUM_IN_PORTS-1:0]               ack_user2buf,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user2buf,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2buf,
  output logic [NUM_OUT_PORTS-1:0]              ack_buf2user,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_buf2interface,
  output logic [NUM_OUT_PORTS-1:0]              vld_buf2interface,
  input  logic [NUM_OUT_PORTS-1:0]              ack_interface2buf,
  output logic                                 idle,
  output logic                                 overflow_err
);
  logic [NUM_IN_PORTS-1:0]  in_empty;
  logic [NUM_IN_PORTS-1:0]  in_trip;
  logic [NUM_OUT_PORTS-1:0] out_empty;
  logic [NUM_OUT_PORTS-1:0] out_trip;

  // Interface->user: the read side faces the user and is gated by decouple.
  for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
    leaf_port_fifo #(
      .DATA_W     (PAYLOAD_BITS),
      .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
      .clk        (clk),
      .rst        (reset),
      .flush      (flush),
      .wr_en      (1'b1),
      .rd_en      (~decouple),
      .wr_data    (din_interface2buf[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld     (vld_interface2buf[k]),
      .wr_ack     (ack_buf2interface[k]),
      .rd_data    (dout_buf2user[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld     (vld_buf2user[k]),
      .rd_ack     (ack_user2buf[k]),
      .empty      (in_empty[k]),
      .stall_trip (in_trip[k])
    );
  end

  // User->interface: the write side faces the user and is gated by decouple.
  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
    leaf_port_fifo #(
      .DATA_W     (PAYLOAD_BITS),
      .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
      .clk        (clk),
      .rst        (reset),
      .flush      (flush),
      .wr_en      (~decouple),
      .rd_en      (1'b1),
      .wr_data    (din_user2buf[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld     (vld_user2buf[k]),
      .wr_ack     (ack_buf2user[k]),
      .rd_data    (dout_buf2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld     (vld_buf2interface[k]),
      .rd_ack     (ack_interface2buf[k]),
      .empty      (out_empty[k]),
      .stall_trip (out_trip[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      idle <= 1'b1;
    end else begin
      idle <= (&in_empty) & (&out_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err <= 1'b0;
    end else if ((|in_trip) || (|out_trip)) begin
      overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_leaf_port_buffer.sv
// Scoreboarded bench for leaf_port_buffer: accepted words are queued per channel and checked on delivery.
module tb_leaf_port_buffer;
  localparam int PB = 32;
  localparam int NI = 6;
  localparam int NO = 5;
  localparam int DB = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             decouple;
  logic [NI*PB-1:0] din_interface2buf;
  logic [NI-1:0]    vld_interface2buf;
  logic [NI-1:0]    ack_buf2interface;
  logic [NI*PB-1:0] dout_buf2user;
  logic [NI-1:0]    vld_buf2user;
  logic [NI-1:0]    ack_user2buf;
  logic [NO*PB-1:0] din_user2buf;
  logic [NO-1:0]    vld_user2buf;
  logic [NO-1:0]    ack_buf2user;
  logic [NO*PB-1:0] dout_buf2interface;
  logic [NO-1:0]    vld_buf2interface;
  logic [NO-1:0]    ack_interface2buf;
  logic             idle;
  logic             overflow_err;

  logic [PB-1:0] sb_in  [NI][$];
  logic [PB-1:0] sb_out [NO][$];
  int rx_in  [NI];
  int rx_out [NO];
  int n_cmp = 0;
  int n_err = 0;

  leaf_port_buffer #(
    .PAYLOAD_BITS  (PB),
    .NUM_IN_PORTS  (NI),
    .NUM_OUT_PORTS (NO),
    .DEPTH_BITS    (DB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .decouple           (decouple),
    .din_interface2buf  (din_interface2buf),
    .vld_interface2buf  (vld_interface2buf),
    .ack_buf2interface  (ack_buf2interface),
    .dout_buf2user      (dout_buf2user),
    .vld_buf2user       (vld_buf2user),
    .ack_user2buf       (ack_user2buf),
    .din_user2buf       (din_user2buf),
    .vld_user2buf       (vld_user2buf),
    .ack_buf2user       (ack_buf2user),
    .dout_buf2interface (dout_buf2interface),
    .vld_buf2interface  (vld_buf2interface),
    .ack_interface2buf  (ack_interface2buf),
    .idle               (idle),
    .overflow_err       (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int k, input logic [PB-1:0] d);
    din_interface2buf[k*PB +: PB] = d;
  endtask

  task automatic set_out(input int k, input logic [PB-1:0] d);
    din_user2buf[k*PB +: PB] = d;
  endtask

  task automatic push_in(input int k, input logic [PB-1:0] d);
    int t;
    t = 0;
    set_in(k, d);
    vld_interface2buf[k] = 1'b1;
    @(negedge clk);
    while (!ack_buf2interface[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ack_buf2interface[k]) chk("push_in_timeout", 32'(ack_buf2interface[k]), 32'd1);
    step();
    vld_interface2buf[k] = 1'b0;
  endtask

  task automatic push_out(input int k, input logic [PB-1:0] d);
    int t;
    t = 0;
    set_out(k, d);
    vld_user2buf[k] = 1'b1;
    @(negedge clk);
    while (!ack_buf2user[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ack_buf2user[k]) chk("push_out_timeout", 32'(ack_buf2user[k]), 32'd1);
    step();
    vld_user2buf[k] = 1'b0;
  endtask

  task automatic clear_sb();
    for (int k = 0; k < NI; k++) sb_in[k].delete();
    for (int k = 0; k < NO; k++) sb_out[k].delete();
  endtask

  // Pops and compares every delivered word, then records every accepted word.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (vld_buf2user[k] && ack_user2buf[k]) begin
        if (sb_in[k].size() == 0) begin
          chk($sformatf("in%0d_unexpected_word", k), 32'(vld_buf2user[k]), 32'd0);
        end else begin
          chk($sformatf("in%0d_data", k), dout_buf2user[k*PB +: PB], sb_in[k].pop_front());
          rx_in[k]++;
        end
      end
      if (vld_interface2buf[k] && ack_buf2interface[k])
        sb_in[k].push_back(din_interface2buf[k*PB +: PB]);
    end
    for (int k = 0; k < NO; k++) begin
      if (vld_buf2interface[k] && ack_interface2buf[k]) begin
        if (sb_out[k].size() == 0) begin
          chk($sformatf("out%0d_unexpected_word", k), 32'(vld_buf2interface[k]), 32'd0);
        end else begin
          chk($sformatf("out%0d_data", k), dout_buf2interface[k*PB +: PB], sb_out[k].pop_front());
          rx_out[k]++;
        end
      end
      if (vld_user2buf[k] && ack_buf2user[k])
        sb_out[k].push_back(din_user2buf[k*PB +: PB]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [PB-1:0] d;
    logic          acc;
    for (int k = 0; k < NI; k++) rx_in[k] = 0;
    for (int k = 0; k < NO; k++) rx_out[k] = 0;
    reset = 1'b1;
    flush = 1'b0;
    decouple = 1'b0;
    din_interface2buf = '0;
    vld_interface2buf = '0;
    ack_user2buf = '0;
    din_user2buf = '0;
    vld_user2buf = '0;
    ack_interface2buf = '0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_ack_in", 32'(ack_buf2interface), 32'd0);
    chk("rst_ack_user", 32'(ack_buf2user), 32'd0);
    chk("rst_vld_user", 32'(vld_buf2user), 32'd0);
    chk("rst_vld_if", 32'(vld_buf2interface), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    step();
    reset = 1'b0;
    ack_user2buf = '1;
    ack_interface2buf = '1;
    @(negedge clk);
    chk("post_rst_ack_in", 32'(ack_buf2interface), 32'h3f);
    chk("post_rst_ack_user", 32'(ack_buf2user), 32'h1f);

    // Three words through input ch0: one-cycle latency, in order, idle lags by a cycle
    step();
    set_in(0, 32'h11);
    vld_interface2buf[0] = 1'b1;
    @(negedge clk);
    chk("t1_ack", 32'(ack_buf2interface[0]), 32'd1);
    chk("t1_no_fallthrough", 32'(vld_buf2user[0]), 32'd0);
    step();
    set_in(0, 32'h22);
    @(negedge clk);
    chk("t1_vld_rise", 32'(vld_buf2user[0]), 32'd1);
    step();
    set_in(0, 32'h33);
    step();
    vld_interface2buf[0] = 1'b0;
    @(negedge clk);
    chk("t1_last_word", 32'(vld_buf2user[0]), 32'd1);
    step();
    @(negedge clk);
    chk("t1_drained", 32'(vld_buf2user[0]), 32'd0);
    chk("t1_idle_lag", 32'(idle), 32'd0);
    step();
    @(negedge clk);
    chk("t1_idle", 32'(idle), 32'd1);
    chk("t1_rx", 32'(rx_in[0]), 32'd3);

    // Fill ch2 to depth, hold the 9th, release the consumer
    step();
    ack_user2buf[2] = 1'b0;
    for (int i = 0; i < 8; i++) push_in(2, 32'h200 + i);
    set_in(2, 32'h208);
    vld_interface2buf[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_full_ack_low", 32'(ack_buf2interface[2]), 32'd0);
      step();
    end
    ack_user2buf[2] = 1'b1;
    @(negedge clk);
    chk("t2_ack_low_at_read", 32'(ack_buf2interface[2]), 32'd0);
    chk("t2_vld_user", 32'(vld_buf2user[2]), 32'd1);
    step();
    @(negedge clk);
    chk("t2_ninth_accepted", 32'(ack_buf2interface[2]), 32'd1);
    step();
    vld_interface2buf[2] = 1'b0;
    repeat (12) step();
    chk("t2_rx", 32'(rx_in[2]), 32'd9);

    // Output ch4 full, then simultaneous read/write for 20 cycles
    ack_interface2buf[4] = 1'b0;
    for (int i = 0; i < 8; i++) push_out(4, 32'h400 + i);
    @(negedge clk);
    chk("t3_full_ack_low", 32'(ack_buf2user[4]), 32'd0);
    step();
    ack_interface2buf[4] = 1'b1;
    d = 32'h408;
    set_out(4, d);
    vld_user2buf[4] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_vld_tput", 32'(vld_buf2interface[4]), 32'd1);
      chk("t3_ack_tput", 32'(ack_buf2user[4]), (i == 0) ? 32'd0 : 32'd1);
      acc = ack_buf2user[4];
      step();
      if (acc) begin
        d = d + 1;
        set_out(4, d);
      end
    end
    vld_user2buf[4] = 1'b0;
    repeat (12) step();
    chk("t3_rx", 32'(rx_out[4]), 32'd27);

    // Decouple with three words queued on input ch1
    ack_user2buf[1] = 1'b0;
    for (int i = 0; i < 3; i++) push_in(1, 32'h100 + i);
    decouple = 1'b1;
    ack_user2buf[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4_vld_user", 32'(vld_buf2user), 32'd0);
      chk("t4_ack_user", 32'(ack_buf2user), 32'd0);
      chk("t4_dout_zero", 32'(|dout_buf2user), 32'd0);
      step();
    end
    chk("t4_retained", 32'(idle), 32'd0);
    chk("t4_rx_held", 32'(rx_in[1]), 32'd0);
    decouple = 1'b0;
    @(negedge clk);
    chk("t4_resume", 32'(vld_buf2user[1]), 32'd1);
    repeat (6) step();
    chk("t4_rx", 32'(rx_in[1]), 32'd3);

    // Flush in the middle of a burst on every channel
    ack_user2buf = '0;
    ack_interface2buf = '0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < NI; k++) set_in(k, {16'hB000 + 16'(c), 16'(k)});
      for (int k = 0; k < NO; k++) set_out(k, {16'hC000 + 16'(c), 16'(k)});
      vld_interface2buf = '1;
      vld_user2buf = '1;
      step();
    end
    flush = 1'b1;
    for (int k = 0; k < NI; k++) set_in(k, 32'hDEAD0000 | k);
    for (int k = 0; k < NO; k++) set_out(k, 32'hDEAD0100 | k);
    @(negedge clk);
    chk("t5_ack_in", 32'(ack_buf2interface), 32'd0);
    chk("t5_ack_user", 32'(ack_buf2user), 32'd0);
    chk("t5_vld_user", 32'(vld_buf2user), 32'd0);
    chk("t5_vld_if", 32'(vld_buf2interface), 32'd0);
    clear_sb();
    step();
    flush = 1'b0;
    vld_interface2buf = '0;
    vld_user2buf = '0;
    ack_user2buf = '1;
    ack_interface2buf = '1;
    @(negedge clk);
    chk("t5_idle", 32'(idle), 32'd1);
    chk("t5_vld_user_after", 32'(vld_buf2user), 32'd0);
    chk("t5_vld_if_after", 32'(vld_buf2interface), 32'd0);
    repeat (4) step();

    // Stall watchdog on input ch3: sticky through flush, cleared by reset
    ack_user2buf[3] = 1'b0;
    for (int i = 0; i < 8; i++) push_in(3, 32'h300 + i);
    set_in(3, 32'h308);
    vld_interface2buf[3] = 1'b1;
    repeat (40) step();
    @(negedge clk);
    chk("t6_ovf_early", 32'(overflow_err), 32'd0);
    repeat (40) step();
    @(negedge clk);
    chk("t6_ovf_set", 32'(overflow_err), 32'd1);
    step();
    vld_interface2buf[3] = 1'b0;
    flush = 1'b1;
    clear_sb();
    step();
    flush = 1'b0;
    ack_user2buf = '1;
    @(negedge clk);
    chk("t6_ovf_after_flush", 32'(overflow_err), 32'd1);
    chk("t6_idle_after_flush", 32'(idle), 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ovf_cleared", 32'(overflow_err), 32'd0);
    chk("t6_ack_after_rst", 32'(ack_buf2interface), 32'h3f);
    repeat (3) step();

    for (int k = 0; k < NI; k++) chk($sformatf("end_sb_in%0d", k), 32'(sb_in[k].size()), 32'd0);
    for (int k = 0; k < NO; k++) chk($sformatf("end_sb_out%0d", k), 32'(sb_out[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
